// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for a five-stage pipeline: load-use stalls, branch flushes,
// data-memory wait freezes with a timeout that parks the pipeline in ERROR until reset.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  rs1Address_ID,
   input  logic [4:0]  rs2Address_ID,
   input  logic        usesRs1_ID,
   input  logic        usesRs2_ID,
   input  logic [4:0]  rdAddress_EX,
   input  logic        memRead_EX,
   input  logic        branchTaken_EX,
   input  logic        memRequest_MEM,
   input  logic        memReady,
   output logic        pcEnable,
   output logic        ifidEnable,
   output logic        idexEnable,
   output logic        exmemEnable,
   output logic        memwbEnable,
   output logic        ifidFlush,
   output logic        idexFlush,
   output logic        memwbFlush,
   output logic        memError,
   output logic [15:0] stallCount
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   // Last permitted value of the incremented wait counter before giving up on memory.
   localparam logic [8:0] TIMEOUT_LAST = 9'(MEM_TIMEOUT - 1);

   state_t      state_reg;
   state_t      state_next;
   logic [7:0]  wait_count_reg;
   logic [7:0]  wait_count_next;
   logic [8:0]  wait_inc;
   logic [15:0] stall_count_reg;
   logic [15:0] stall_count_next;
   logic        mem_error_reg;

   logic [4:0]  src_addr [2];
   logic        src_used [2];
   logic [1:0]  src_match;
   logic        load_use;
   logic        mem_freeze;

   assign src_addr[0] = rs1Address_ID;
   assign src_addr[1] = rs2Address_ID;
   assign src_used[0] = usesRs1_ID;
   assign src_used[1] = usesRs2_ID;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign src_match[gi] = src_used[gi] && (src_addr[gi] == rdAddress_EX);
      end
   endgenerate

   // x0 is never a real producer, so a load targeting it cannot create a hazard.
   assign load_use   = memRead_EX && (rdAddress_EX != 5'd0) && (|src_match);
   assign mem_freeze = memRequest_MEM && !memReady && (state_reg != ERROR);

   always_comb begin
      pcEnable    = 1'b0;
      ifidEnable  = 1'b0;
      idexEnable  = 1'b0;
      exmemEnable = 1'b0;
      memwbEnable = 1'b0;
      ifidFlush   = 1'b0;
      idexFlush   = 1'b0;
      memwbFlush  = 1'b0;
      if (!reset || state_reg == ERROR) begin
         pcEnable = 1'b0;
      end else if (mem_freeze) begin
         // Whole pipe holds; WB receives a bubble so the stalled write is not repeated.
         memwbFlush = 1'b1;
      end else if (branchTaken_EX) begin
         pcEnable    = 1'b1;
         ifidEnable  = 1'b1;
         idexEnable  = 1'b1;
         exmemEnable = 1'b1;
         memwbEnable = 1'b1;
         ifidFlush   = 1'b1;
         idexFlush   = 1'b1;
      end else if (load_use) begin
         idexEnable  = 1'b1;
         exmemEnable = 1'b1;
         memwbEnable = 1'b1;
         idexFlush   = 1'b1;
      end else begin
         pcEnable    = 1'b1;
         ifidEnable  = 1'b1;
         idexEnable  = 1'b1;
         exmemEnable = 1'b1;
         memwbEnable = 1'b1;
      end
   end

   assign wait_inc = {1'b0, wait_count_reg} + 9'd1;

   always_comb begin
      state_next      = state_reg;
      wait_count_next = wait_count_reg;
      case (state_reg)
         RUN: begin
            if (mem_freeze) begin
               state_next      = MEM_WAIT;
               wait_count_next = 8'd0;
            end
         end
         MEM_WAIT: begin
            if (!mem_freeze) begin
               state_next = RUN;
            end else begin
               wait_count_next = wait_inc[7:0];
               if (wait_inc >= TIMEOUT_LAST) begin
                  state_next = ERROR;
               end
            end
         end
         ERROR: begin
            state_next = ERROR;
         end
         default: begin
            state_next      = RUN;
            wait_count_next = 8'd0;
         end
      endcase
   end

   always_comb begin
      stall_count_next = stall_count_reg;
      if (!pcEnable && state_reg != ERROR && stall_count_reg != 16'hFFFF) begin
         stall_count_next = stall_count_reg + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= RUN;
         wait_count_reg  <= 8'd0;
         stall_count_reg <= 16'd0;
         mem_error_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wait_count_reg  <= wait_count_next;
         stall_count_reg <= stall_count_next;
         mem_error_reg   <= (state_next == ERROR);
      end
   end

   assign memError   = mem_error_reg;
   assign stallCount = stall_count_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle expected controls queued with the stimulus
// and compared half a cycle later; stallCount tracked by a small saturating model.
module tb_pipeline_hazard_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1Address_ID, rs2Address_ID, rdAddress_EX;
   logic        usesRs1_ID, usesRs2_ID, memRead_EX, branchTaken_EX;
   logic        memRequest_MEM, memReady;
   logic        pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable;
   logic        ifidFlush, idexFlush, memwbFlush, memError;
   logic [15:0] stallCount;
   logic [7:0]  ctl;

   typedef struct packed {
      logic [7:0]  ctl;
      logic        err;
      logic [15:0] stall;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_stall = 16'd0;

   // {pc, ifid, idex, exmem, memwb, ifidFlush, idexFlush, memwbFlush}
   localparam logic [7:0] C_NORMAL  = 8'b11111_000;
   localparam logic [7:0] C_FREEZE  = 8'b00000_001;
   localparam logic [7:0] C_BRANCH  = 8'b11111_110;
   localparam logic [7:0] C_LOADUSE = 8'b00111_010;
   localparam logic [7:0] C_HALT    = 8'b00000_000;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
      .clk            (clk),
      .reset          (reset),
      .rs1Address_ID  (rs1Address_ID),
      .rs2Address_ID  (rs2Address_ID),
      .usesRs1_ID     (usesRs1_ID),
      .usesRs2_ID     (usesRs2_ID),
      .rdAddress_EX   (rdAddress_EX),
      .memRead_EX     (memRead_EX),
      .branchTaken_EX (branchTaken_EX),
      .memRequest_MEM (memRequest_MEM),
      .memReady       (memReady),
      .pcEnable       (pcEnable),
      .ifidEnable     (ifidEnable),
      .idexEnable     (idexEnable),
      .exmemEnable    (exmemEnable),
      .memwbEnable    (memwbEnable),
      .ifidFlush      (ifidFlush),
      .idexFlush      (idexFlush),
      .memwbFlush     (memwbFlush),
      .memError       (memError),
      .stallCount     (stallCount)
   );

   assign ctl = {pcEnable, ifidEnable, idexEnable, exmemEnable, memwbEnable,
                 ifidFlush, idexFlush, memwbFlush};

   initial forever #5 clk = ~clk;

   task automatic idle();
      rs1Address_ID  = 5'd0;
      rs2Address_ID  = 5'd0;
      rdAddress_EX   = 5'd0;
      usesRs1_ID     = 1'b0;
      usesRs2_ID     = 1'b0;
      memRead_EX     = 1'b0;
      branchTaken_EX = 1'b0;
      memRequest_MEM = 1'b0;
      memReady       = 1'b0;
   endtask

   task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2);
      memRead_EX    = 1'b1;
      rdAddress_EX  = rd;
      rs1Address_ID = rs1;
      usesRs1_ID    = u1;
      rs2Address_ID = rs2;
      usesRs2_ID    = u2;
   endtask

   // Called at a falling edge with inputs already applied; returns at the next falling edge.
   task automatic txn(input string name, input logic [7:0] exp_ctl, input logic exp_err);
      exp_t e;
      e.ctl   = exp_ctl;
      e.err   = exp_err;
      e.stall = exp_stall;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ctl !== e.ctl) begin
         failures++;
         $display("FAIL %s ctl: got %b expected %b", name, ctl, e.ctl);
      end
      checks++;
      if (memError !== e.err) begin
         failures++;
         $display("FAIL %s memError: got %b expected %b", name, memError, e.err);
      end
      checks++;
      if (stallCount !== e.stall) begin
         failures++;
         $display("FAIL %s stallCount: got %h expected %h", name, stallCount, e.stall);
      end
      $display("txn %-14s ctl=%b memError=%b stallCount=%h", name, ctl, memError, stallCount);
      if (!e.ctl[7] && !e.err && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle();
      memRequest_MEM = 1'b1;
      branchTaken_EX = 1'b1;
      #1;
      checks++;
      if (ctl !== C_HALT || memError !== 1'b0 || stallCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_hold: got ctl=%b err=%b stall=%h expected all zero", ctl, memError, stallCount);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (ctl !== C_HALT || memError !== 1'b0 || stallCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_clocked: got ctl=%b err=%b stall=%h expected all zero", ctl, memError, stallCount);
      end
      $display("txn reset         ctl=%b memError=%b stallCount=%h", ctl, memError, stallCount);
      idle();
      reset     = 1'b1;
      exp_stall = 16'd0;
      txn("normal_first", C_NORMAL, 1'b0);
   endtask

   task automatic test_normal();
      idle();
      txn("idle", C_NORMAL, 1'b0);
      memReady = 1'b1;
      txn("ready_no_req", C_NORMAL, 1'b0);
      idle();
      set_load_use(5'd7, 5'd6, 1'b1, 5'd8, 1'b1);
      txn("load_no_match", C_NORMAL, 1'b0);
      set_load_use(5'd7, 5'd7, 1'b0, 5'd7, 1'b0);
      txn("load_unused", C_NORMAL, 1'b0);
      idle();
      set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
      memRead_EX = 1'b0;
      txn("alu_match", C_NORMAL, 1'b0);
   endtask

   task automatic test_load_use();
      idle();
      set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      txn("loaduse_rs1", C_LOADUSE, 1'b0);
      idle();
      txn("after_rs1", C_NORMAL, 1'b0);
      set_load_use(5'd12, 5'd3, 1'b1, 5'd12, 1'b1);
      txn("loaduse_rs2", C_LOADUSE, 1'b0);
      idle();
      txn("after_rs2", C_NORMAL, 1'b0);
      set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
      txn("rd_zero", C_NORMAL, 1'b0);
   endtask

   task automatic test_branch_priority();
      idle();
      set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      branchTaken_EX = 1'b1;
      txn("branch_over_lu", C_BRANCH, 1'b0);
      idle();
      txn("after_branch", C_NORMAL, 1'b0);
   endtask

   task automatic test_mem_wait();
      idle();
      memRequest_MEM = 1'b1;
      txn("freeze1", C_FREEZE, 1'b0);
      set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
      branchTaken_EX = 1'b1;
      txn("freeze2_prio", C_FREEZE, 1'b0);
      idle();
      memRequest_MEM = 1'b1;
      txn("freeze3", C_FREEZE, 1'b0);
      memReady = 1'b1;
      txn("mem_ready", C_NORMAL, 1'b0);
      idle();
      txn("after_mem", C_NORMAL, 1'b0);
   endtask

   task automatic test_back_to_back();
      idle();
      memRequest_MEM = 1'b1;
      txn("b2b_freeze", C_FREEZE, 1'b0);
      memReady       = 1'b1;
      branchTaken_EX = 1'b1;
      txn("b2b_ready_br", C_BRANCH, 1'b0);
      idle();
      set_load_use(5'd9, 5'd0, 1'b0, 5'd9, 1'b1);
      txn("b2b_loaduse", C_LOADUSE, 1'b0);
      idle();
      memRequest_MEM = 1'b1;
      txn("b2b_freeze2", C_FREEZE, 1'b0);
      memReady = 1'b1;
      txn("b2b_ready2", C_NORMAL, 1'b0);
      idle();
      txn("b2b_idle", C_NORMAL, 1'b0);
   endtask

   task automatic test_timeout_and_reset();
      idle();
      memRequest_MEM = 1'b1;
      for (int i = 0; i < 4; i++) txn($sformatf("to_freeze%0d", i), C_FREEZE, 1'b0);
      txn("to_error", C_HALT, 1'b1);
      memReady = 1'b1;
      txn("err_ready", C_HALT, 1'b1);
      idle();
      branchTaken_EX = 1'b1;
      txn("err_branch", C_HALT, 1'b1);
      idle();
      txn("err_idle", C_HALT, 1'b1);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ctl !== C_HALT || memError !== 1'b0 || stallCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_in_error: got ctl=%b err=%b stall=%h expected all zero", ctl, memError, stallCount);
      end
      @(negedge clk);
      reset     = 1'b1;
      exp_stall = 16'd0;
      txn("post_err_rst", C_NORMAL, 1'b0);
   endtask

   task automatic test_reset_mid_wait();
      idle();
      memRequest_MEM = 1'b1;
      txn("mw_freeze1", C_FREEZE, 1'b0);
      txn("mw_freeze2", C_FREEZE, 1'b0);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (ctl !== C_HALT || memError !== 1'b0 || stallCount !== 16'd0) begin
         failures++;
         $display("FAIL reset_in_wait: got ctl=%b err=%b stall=%h expected all zero", ctl, memError, stallCount);
      end
      @(negedge clk);
      idle();
      reset     = 1'b1;
      exp_stall = 16'd0;
      txn("mw_post_rst", C_NORMAL, 1'b0);
      // A fresh timeout window: three freezes must not trip ERROR with MEM_TIMEOUT=4.
      memRequest_MEM = 1'b1;
      for (int i = 0; i < 3; i++) txn($sformatf("mw_refreeze%0d", i), C_FREEZE, 1'b0);
      memReady = 1'b1;
      txn("mw_ready", C_NORMAL, 1'b0);
      idle();
      txn("mw_idle", C_NORMAL, 1'b0);
   endtask

   task automatic test_saturation();
      int n;
      idle();
      set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
      n = int'(16'hFFFE - exp_stall);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         exp_stall = exp_stall + 16'd1;
      end
      txn("sat_fffe", C_LOADUSE, 1'b0);
      txn("sat_ffff", C_LOADUSE, 1'b0);
      txn("sat_hold1", C_LOADUSE, 1'b0);
      txn("sat_hold2", C_LOADUSE, 1'b0);
      idle();
      txn("sat_idle", C_NORMAL, 1'b0);
   endtask

   initial begin
      idle();
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_normal();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_back_to_back();
      test_timeout_and_reset();
      test_reset_mid_wait();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
